// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB fade sequencer: default duty width,
// FSM state encoding and the fixed 8-entry colour palette.
package rgb_pkg;

  localparam int unsigned DUTY_W_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FADE = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  // Palette walk: black, red, yellow, green, cyan, blue, magenta, white.
  function automatic rgb24_t palette_color(input logic [2:0] idx);
    rgb24_t c;
    c = rgb24_t'(24'h000000);
    case (idx)
      3'd0:    c = rgb24_t'(24'h000000);
      3'd1:    c = rgb24_t'(24'hFF0000);
      3'd2:    c = rgb24_t'(24'hFFFF00);
      3'd3:    c = rgb24_t'(24'h00FF00);
      3'd4:    c = rgb24_t'(24'h00FFFF);
      3'd5:    c = rgb24_t'(24'h0000FF);
      3'd6:    c = rgb24_t'(24'hFF00FF);
      3'd7:    c = rgb24_t'(24'hFFFFFF);
      default: c = rgb24_t'(24'h000000);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that emits a one-cycle tick every TICK_DIV enabled
// cycles; clr parks the count at zero, en=0 freezes it.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic CLK100MHZ,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick = en && !clr && (cnt == CNT_LAST);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Generates six RGB duty values: LED1 fades one LSB per tick through the
// palette, holds at each colour, and LED2 shows the complement of LED1.
module rgb_fade_sequencer
  import rgb_pkg::*;
#(
  parameter int unsigned DUTY_W     = DUTY_W_DEF,
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned HOLD_TICKS = 500
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  input  logic              enable,
  input  logic              mode,
  input  logic              step_req,
  output logic [DUTY_W-1:0] duty1_r,
  output logic [DUTY_W-1:0] duty1_g,
  output logic [DUTY_W-1:0] duty1_b,
  output logic [DUTY_W-1:0] duty2_r,
  output logic [DUTY_W-1:0] duty2_g,
  output logic [DUTY_W-1:0] duty2_b,
  output logic [2:0]        color_idx,
  output logic              busy
);

  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS);
  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

  // Palette levels are all-or-nothing, so they map onto full scale of DUTY_W.
  function automatic logic [DUTY_W-1:0] chan_target(input logic [7:0] level);
    return (level != 8'h00) ? DUTY_MAX : '0;
  endfunction

  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    logic [DUTY_W-1:0] nxt;
    nxt = cur;
    if (cur < tgt) begin
      nxt = cur + DUTY_W'(1);
    end else if (cur > tgt) begin
      nxt = cur - DUTY_W'(1);
    end
    return nxt;
  endfunction

  logic [1:0]        state, state_nxt;
  logic [2:0]        idx_nxt;
  logic [DUTY_W-1:0] r_nxt, g_nxt, b_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              busy_nxt;

  logic              tick;
  logic              presc_clr;
  rgb24_t            pal;
  logic [DUTY_W-1:0] tgt_r, tgt_g, tgt_b;
  logic              at_target;
  logic              hold_done;
  logic              advance;

  assign presc_clr = (state == ST_IDLE);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .CLK100MHZ(CLK100MHZ),
    .rst      (rst),
    .en       (enable),
    .clr      (presc_clr),
    .tick     (tick)
  );

  assign pal       = palette_color(color_idx);
  assign tgt_r     = chan_target(pal.r);
  assign tgt_g     = chan_target(pal.g);
  assign tgt_b     = chan_target(pal.b);
  assign at_target = (duty1_r == tgt_r) && (duty1_g == tgt_g) && (duty1_b == tgt_b);
  assign hold_done = (hold_cnt == HOLD_LAST);
  // Auto and manual advance are mutually exclusive, so a coincident request advances once.
  assign advance   = mode ? step_req : hold_done;

  // State register and all datapath registers; enable=0 leaves every next value unchanged.
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      color_idx <= '0;
      duty1_r   <= '0;
      duty1_g   <= '0;
      duty1_b   <= '0;
      hold_cnt  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      color_idx <= idx_nxt;
      duty1_r   <= r_nxt;
      duty1_g   <= g_nxt;
      duty1_b   <= b_nxt;
      hold_cnt  <= hold_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    idx_nxt   = color_idx;
    r_nxt     = duty1_r;
    g_nxt     = duty1_g;
    b_nxt     = duty1_b;
    hold_nxt  = hold_cnt;
    if (enable) begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_FADE;
          idx_nxt   = '0;
        end
        ST_FADE: begin
          if (at_target) begin
            state_nxt = ST_HOLD;
            hold_nxt  = '0;
          end else if (tick) begin
            r_nxt = step_toward(duty1_r, tgt_r);
            g_nxt = step_toward(duty1_g, tgt_g);
            b_nxt = step_toward(duty1_b, tgt_b);
          end
        end
        ST_HOLD: begin
          if (tick && !hold_done) begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end
          if (advance) begin
            idx_nxt   = color_idx + 3'd1;
            state_nxt = ST_FADE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
    busy_nxt = (state_nxt == ST_FADE);
  end

  // LED2 is the complement of the registered LED1 duties.
  assign duty2_r = DUTY_MAX - duty1_r;
  assign duty2_g = DUTY_MAX - duty1_g;
  assign duty2_b = DUTY_MAX - duty1_b;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Scoreboard bench: a palette-walk model predicts the ordered list of
// distinct {idx,R,G,B} snapshots; a monitor pops one per observed change.
module tb_rgb_fade_sequencer;

  localparam int unsigned DUTY_W     = 8;
  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned HOLD_TICKS = 2;
  localparam int          DMAX       = 255;
  localparam logic [23:0] PAL [8] = '{24'h000000, 24'hFF0000, 24'hFFFF00, 24'h00FF00,
                                      24'h00FFFF, 24'h0000FF, 24'hFF00FF, 24'hFFFFFF};

  logic clk = 1'b0;
  logic rst, enable, mode, step_req;
  logic [DUTY_W-1:0] duty1_r, duty1_g, duty1_b, duty2_r, duty2_g, duty2_b;
  logic [2:0] color_idx;
  logic busy;

  rgb_fade_sequencer #(
    .DUTY_W(DUTY_W), .TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .CLK100MHZ(clk), .rst(rst), .enable(enable), .mode(mode), .step_req(step_req),
    .duty1_r(duty1_r), .duty1_g(duty1_g), .duty1_b(duty1_b),
    .duty2_r(duty2_r), .duty2_g(duty2_g), .duty2_b(duty2_b),
    .color_idx(color_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [26:0] exp_q [$];
  int adv_end [16];
  bit mon_on = 1'b0;
  int popped = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int lvl(input logic [23:0] c, input int ch);
    logic [7:0] v;
    v = 8'(c >> (16 - 8 * ch));
    return (v != 8'h00) ? DMAX : 0;
  endfunction

  function automatic logic [26:0] snap(input int idx, input int r, input int g, input int b);
    return {3'(idx), 8'(r), 8'(g), 8'(b)};
  endfunction

  // Walk the palette from reset: each advance moves idx by one, then every
  // channel moves one LSB per tick toward the new colour until all arrive.
  task automatic gen_traj(input int n_adv);
    int cur [3];
    int tgt [3];
    int v [3];
    int idx, maxd, d;
    exp_q.delete();
    cur = '{0, 0, 0};
    idx = 0;
    for (int a = 0; a < n_adv; a++) begin
      idx = (idx + 1) % 8;
      exp_q.push_back(snap(idx, cur[0], cur[1], cur[2]));
      maxd = 0;
      for (int c = 0; c < 3; c++) begin
        tgt[c] = lvl(PAL[idx], c);
        d = (tgt[c] > cur[c]) ? tgt[c] - cur[c] : cur[c] - tgt[c];
        if (d > maxd) maxd = d;
      end
      for (int s = 1; s <= maxd; s++) begin
        for (int c = 0; c < 3; c++) begin
          if (tgt[c] > cur[c]) v[c] = cur[c] + ((s < tgt[c] - cur[c]) ? s : tgt[c] - cur[c]);
          else                 v[c] = cur[c] - ((s < cur[c] - tgt[c]) ? s : cur[c] - tgt[c]);
        end
        exp_q.push_back(snap(idx, v[0], v[1], v[2]));
      end
      cur = tgt;
      adv_end[a] = exp_q.size();
    end
    popped = 0;
  endtask

  // Monitor: compare every change of the LED1 snapshot against the model.
  logic [26:0] last_snap, cur_snap, exp_snap;
  bit en_prev = 1'b0;
  bit armed = 1'b0;
  int en_cnt = 0;
  always @(negedge clk) begin
    cur_snap = {color_idx, duty1_r, duty1_g, duty1_b};
    if (!mon_on) begin
      last_snap = cur_snap;
      en_cnt = 0;
      armed = 1'b0;
    end else begin
      if (en_prev) en_cnt++;
      if (cur_snap != last_snap) begin
        check("change_while_enabled", en_prev, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %0h expected no further change", cur_snap);
        end else begin
          exp_snap = exp_q.pop_front();
          popped++;
          check("sb_snapshot", cur_snap, exp_snap);
        end
        check("duty2_r", duty2_r, DMAX - int'(duty1_r));
        check("duty2_g", duty2_g, DMAX - int'(duty1_g));
        check("duty2_b", duty2_b, DMAX - int'(duty1_b));
        if (cur_snap[26:24] == last_snap[26:24]) begin
          if (armed) check("tick_spacing", en_cnt, TICK_DIV);
          armed = 1'b1;
        end else begin
          armed = 1'b0;
        end
        en_cnt = 0;
        last_snap = cur_snap;
      end
    end
    en_prev = enable;
  end

  task automatic tick_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // kind: 0 idx==val, 1 duty1_r==val, 2 duty1_g==val, 3 busy==val
  task automatic wait_cond(input int kind, input int val, input int budget, input string name);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      case (kind)
        0: hit = (int'(color_idx) == val);
        1: hit = (int'(duty1_r) == val);
        2: hit = (int'(duty1_g) == val);
        default: hit = (int'(busy) == val);
      endcase
      if (!hit) begin
        tick_clk(1);
        n++;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got no match after %0d cycles, required value %0d", name, n, val);
    end
  endtask

  int n_resume;
  int cyc;

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 1'b0; step_req = 1'b0;
    tick_clk(3);
    check("rst_duty1_r", duty1_r, 0);
    check("rst_duty1_g", duty1_g, 0);
    check("rst_duty1_b", duty1_b, 0);
    check("rst_duty2_r", duty2_r, DMAX);
    check("rst_duty2_g", duty2_g, DMAX);
    check("rst_duty2_b", duty2_b, DMAX);
    check("rst_idx", color_idx, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick_clk(5);
    check("idle_disabled_busy", busy, 0);

    // Auto run: black passes straight to HOLD, then idx 1 fades red up.
    gen_traj(10);
    mon_on = 1'b1;
    enable = 1'b1;
    wait_cond(0, 1, 200, "adv_to_1");
    check("busy_in_fade", busy, 1);

    // Freeze mid-fade two enabled cycles after the r=100 step.
    wait_cond(1, 100, 2000, "reach_r100");
    tick_clk(2);
    enable = 1'b0;
    tick_clk(1000);
    check("frozen_r", duty1_r, 100);
    check("frozen_g", duty1_g, 0);
    check("frozen_idx", color_idx, 1);
    check("frozen_busy", busy, 1);
    enable = 1'b1;
    n_resume = 0;
    while (duty1_r == 8'd100 && n_resume < 20) begin
      tick_clk(1);
      n_resume++;
    end
    check("resume_latency", n_resume, TICK_DIV - 2);

    // Manual mode at idx 2; a step_req during fade must be ignored.
    wait_cond(0, 2, 2000, "adv_to_2");
    mode = 1'b1;
    tick_clk(5);
    step_req = 1'b1;
    tick_clk(1);
    step_req = 1'b0;
    wait_cond(3, 0, 2000, "hold_at_2");
    tick_clk(4 * 50);
    check("manual_no_adv_idx", color_idx, 2);
    check("manual_no_adv_busy", busy, 0);
    step_req = 1'b1;
    tick_clk(1);
    step_req = 1'b0;
    check("manual_step_idx", color_idx, 3);
    check("manual_step_busy", busy, 1);
    tick_clk(3);
    step_req = 1'b1;
    tick_clk(1);
    step_req = 1'b0;
    wait_cond(3, 0, 2000, "hold_at_3");
    tick_clk(40);
    check("fade_step_ignored", color_idx, 3);

    // Randomised run through the wrap from white back to black.
    cyc = 0;
    while (popped < adv_end[7] && cyc < 60000) begin
      if (cyc % 50 == 0) mode = ($urandom_range(0, 3) == 0);
      enable = ($urandom_range(0, 7) != 0);
      step_req = mode && ($urandom_range(0, 15) == 0);
      tick_clk(1);
      cyc++;
    end
    if (popped < adv_end[7]) begin
      checks++;
      errors++;
      $display("FAIL timeout_random_run: got %0d snapshots required %0d", popped, adv_end[7]);
    end
    mode = 1'b0;
    step_req = 1'b0;
    enable = 1'b1;

    // Auto hold at black with step_req held across the expiry cycle.
    wait_cond(3, 0, 100, "hold_at_0");
    check("wrap_idx", color_idx, 0);
    step_req = 1'b1;
    wait_cond(0, 1, 200, "wrap_adv_to_1");
    step_req = 1'b0;
    tick_clk(20);
    check("coincident_single_adv", color_idx, 1);

    // Asynchronous reset mid-fade at g=37.
    wait_cond(0, 2, 3000, "adv_to_2_again");
    wait_cond(2, 37, 2000, "reach_g37");
    mon_on = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("async_rst_g", duty1_g, 0);
    check("async_rst_r", duty1_r, 0);
    check("async_rst_duty2_g", duty2_g, DMAX);
    check("async_rst_idx", color_idx, 0);
    check("async_rst_busy", busy, 0);
    tick_clk(2);
    gen_traj(2);
    mon_on = 1'b1;
    rst = 1'b0;
    wait_cond(0, 1, 200, "restart_adv_to_1");
    wait_cond(1, 10, 300, "restart_r10");
    tick_clk(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
